// File: rtl/encode_8_input_seq.sv
// Sequential 8-to-3 encoder: captures a request vector on a load strobe and
// hands out set-bit indices lowest first, one per valid/ready transfer.
module encode_8_input_seq #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [(1<<N)-1:0] en_in,
  input  logic              en_load,
  output logic [N-1:0]      en_out,
  output logic              en_valid,
  input  logic              en_ready,
  output logic              en_busy,
  output logic [N:0]        en_count,
  output logic              en_zero,
  output logic              en_drop
);

  localparam int W = 1 << N;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   pending_reg, pending_next;
  logic [N-1:0]   out_reg, out_next;
  logic [N:0]     count_reg, count_next;
  logic           valid_reg, busy_reg, zero_reg, drop_reg;
  logic           zero_next, drop_next;
  logic [W-1:0]   served_mask;

  // One-hot mask of the index currently presented to the consumer.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_mask
      assign served_mask[gi] = (out_reg == N'(gi));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    zero_next    = 1'b0;
    drop_next    = 1'b0;
    out_next     = '0;
    count_next   = '0;
    case (state_reg)
      IDLE: begin
        if (en_load) begin
          if (en_in != '0) begin
            pending_next = en_in;
            state_next   = SERVE;
          end else begin
            zero_next = 1'b1;
          end
        end
      end
      SERVE: begin
        // A load is refused for the whole SERVE state, final transfer included.
        drop_next = en_load;
        if (valid_reg && en_ready) begin
          pending_next = pending_reg & ~served_mask;
          if (pending_next == '0) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Scan downward so the lowest set bit wins.
    for (int i = W - 1; i >= 0; i--) begin
      if (pending_next[i]) out_next = N'(i);
    end
    for (int i = 0; i < W; i++) begin
      count_next = count_next + (N+1)'(pending_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      out_reg     <= '0;
      count_reg   <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      zero_reg    <= 1'b0;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      out_reg     <= out_next;
      count_reg   <= count_next;
      valid_reg   <= (state_next == SERVE);
      busy_reg    <= (state_next == SERVE);
      zero_reg    <= zero_next;
      drop_reg    <= drop_next;
    end
  end

  assign en_out   = out_reg;
  assign en_valid = valid_reg;
  assign en_busy  = busy_reg;
  assign en_count = count_reg;
  assign en_zero  = zero_reg;
  assign en_drop  = drop_reg;

endmodule

// File: tb/tb_encode_8_input_seq.sv
// Directed bench for encode_8_input_seq: hand-computed index/count sequences.
module tb_encode_8_input_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] en_in;
  logic       en_load;
  logic [2:0] en_out;
  logic       en_valid;
  logic       en_ready;
  logic       en_busy;
  logic [3:0] en_count;
  logic       en_zero;
  logic       en_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encode_8_input_seq #(.N(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_in    (en_in),
    .en_load  (en_load),
    .en_out   (en_out),
    .en_valid (en_valid),
    .en_ready (en_ready),
    .en_busy  (en_busy),
    .en_count (en_count),
    .en_zero  (en_zero),
    .en_drop  (en_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " valid"}, 32'(en_valid), 32'd0);
    check({tag, " busy"},  32'(en_busy),  32'd0);
    check({tag, " count"}, 32'(en_count), 32'd0);
  endtask

  task automatic expect_serve(input string tag, input int idx, input int cnt);
    check({tag, " valid"}, 32'(en_valid), 32'd1);
    check({tag, " out"},   32'(en_out),   32'(idx));
    check({tag, " count"}, 32'(en_count), 32'(cnt));
  endtask

  task automatic load(input logic [7:0] v);
    en_in   = v;
    en_load = 1'b1;
    step();
    en_load = 1'b0;
    en_in   = 8'hxx;
  endtask

  initial begin
    rst = 1'b1; en_in = 8'h00; en_load = 1'b0; en_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    expect_idle("reset");
    check("reset out",  32'(en_out),  32'd0);
    check("reset zero", 32'(en_zero), 32'd0);
    check("reset drop", 32'(en_drop), 32'd0);
    rst = 1'b0;
    step();

    // 1010_0100 -> 2,5,7
    en_ready = 1'b1;
    load(8'b1010_0100);
    check("a4 busy", 32'(en_busy), 32'd1);
    expect_serve("a4 #0", 2, 3); step();
    expect_serve("a4 #1", 5, 2); step();
    expect_serve("a4 #2", 7, 1); step();
    expect_idle("a4 done");

    // Full vector
    load(8'hFF);
    for (int i = 0; i < 8; i++) begin
      expect_serve($sformatf("ff #%0d", i), i, 8 - i);
      step();
    end
    expect_idle("ff done");

    // Stall holds output stable
    en_ready = 1'b0;
    load(8'b0001_0010);
    for (int i = 0; i < 4; i++) begin
      expect_serve($sformatf("stall %0d", i), 1, 2);
      step();
    end
    en_ready = 1'b1;
    expect_serve("12 #0", 1, 2); step();
    expect_serve("12 #1", 4, 1); step();
    expect_idle("12 done");

    // All-zero load
    load(8'h00);
    check("zero pulse", 32'(en_zero), 32'd1);
    check("zero valid", 32'(en_valid), 32'd0);
    step();
    check("zero clear", 32'(en_zero), 32'd0);

    // Load while serving is dropped
    en_ready = 1'b0;
    load(8'b0001_0010);
    load(8'h80);
    check("drop pulse", 32'(en_drop), 32'd1);
    expect_serve("drop hold", 1, 2);
    step();
    check("drop clear", 32'(en_drop), 32'd0);
    en_ready = 1'b1;
    expect_serve("drop #0", 1, 2); step();
    expect_serve("drop #1", 4, 1); step();
    expect_idle("drop done");

    // Async reset mid-serve
    load(8'b0110_0000);
    expect_serve("60 #0", 5, 2); step();
    expect_serve("60 #1", 6, 1);
    #2 rst = 1'b1;
    #1;
    expect_idle("async rst");
    check("async rst out", 32'(en_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    load(8'h01);
    expect_serve("01 #0", 0, 1); step();
    expect_idle("01 done");

    // Load during final transfer is dropped; next-cycle load accepted
    load(8'h08);
    expect_serve("08 #0", 3, 1);
    en_in = 8'h03; en_load = 1'b1;
    step();
    check("final drop", 32'(en_drop), 32'd1);
    check("final valid", 32'(en_valid), 32'd0);
    step();
    en_load = 1'b0;
    check("reload drop", 32'(en_drop), 32'd0);
    expect_serve("03 #0", 0, 2); step();
    expect_serve("03 #1", 1, 1); step();
    expect_idle("03 done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/encode_8_input_seq.md
Name: encode_8_input_seq

Overview:
Sequential 8-to-3 encoder, the inverse of the 3-to-8 one-hot decoder. Captures an 8-bit request vector on a load strobe and emits the binary index of each set bit, lowest index first, one per valid/ready handshake. Each served bit is cleared from the pending set. Sits between request-collection logic and a consumer that accepts one 3-bit index at a time.

Parameters:
N, 3, index width; input vector width is 1<<N (8 by default)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous reset, active-high
en_in  input  1<<N  request vector, sampled only when en_load=1 in IDLE
en_load  input  1  load strobe
en_out  output  N  binary index of lowest pending bit
en_valid  output  1  en_out holds a valid index
en_ready  input  1  consumer accepts en_out this cycle
en_busy  output  1  block is in SERVE
en_count  output  N+1  number of pending bits, 0..(1<<N)
en_zero  output  1  one-cycle pulse: load of an all-zero vector
en_drop  output  1  one-cycle pulse: load ignored because busy

Behaviour:
- Reset (async, active-high): state=IDLE, pending=0, en_out=0, en_valid=0, en_busy=0, en_count=0, en_zero=0, en_drop=0. Reset asserted mid-SERVE discards all pending bits immediately, with no further handshakes.
- All outputs are driven from registers. There is no combinational path from any input to any output.
- State IDLE:
  - en_load=1 and en_in!=0: pending<=en_in, go to SERVE.
  - en_load=1 and en_in==0: en_zero=1 for the next cycle, stay in IDLE.
  - Load-to-valid latency is 1 cycle: a load at edge t gives en_valid=1 after edge t.
- State SERVE:
  - en_busy=1, en_valid=1.
  - en_out = index of the lowest set bit of pending.
  - en_count = popcount(pending).
- Handshake: a transfer occurs at a rising edge where en_valid=1 and en_ready=1.
  - On transfer: clear pending[en_out], recompute en_out, en_count and en_valid for the next cycle.
  - If the cleared bit was the last one, go to IDLE next cycle with en_valid=0, en_busy=0, en_count=0.
  - No bubble between consecutive transfers: with en_ready held high, one index is transferred per cycle.
- Stall: while en_valid=1 and en_ready=0, en_out, en_count and pending hold stable.
- en_ready while en_valid=0 is ignored.
- en_load=1 while in SERVE: the vector is ignored, pending is unchanged, and en_drop=1 for the next cycle. This holds even in the cycle of the final transfer, so there is no same-cycle reload.
- en_load in the cycle after returning to IDLE is accepted normally.
- Full vector 0xFF: en_count=8 (needs the N+1 width), with indices 0..7 emitted in order.
- Single bit: exactly one transfer occurs, then IDLE.
- en_zero and en_drop are pulses: high for exactly 1 cycle per offending load.
- X-safety: en_in is not sampled outside an IDLE load.

Test Plan:
- Reset, then load en_in=8'b1010_0100 with en_ready=1 -> en_out sequence 2,5,7 on consecutive cycles; en_count 3,2,1; then en_valid=0, en_busy=0.
- Load 8'hFF with en_ready=1 -> indices 0..7 in 8 consecutive cycles; en_count starts at 8.
- Load 8'b0001_0010, hold en_ready=0 for 4 cycles -> en_out=1 and en_count=2 stay stable; release -> 1 then 4.
- Load 8'h00 in IDLE -> en_zero pulses for 1 cycle, en_valid stays 0. Load 8'h80 while serving -> en_drop pulses, pending is unaffected.
- Load 8'b0110_0000, assert rst after the first transfer -> all outputs go to 0 immediately. After release, load 8'h01 -> single index 0.
- Last transfer of 8'h08 coincides with en_load=1 and en_in=8'h03 -> en_drop pulses. The next-cycle load of 8'h03 -> indices 0,1.
